// File: rtl/contador_cm_uc_pkg.sv
// Shared types for the cm-counting control unit: state codes and default sizing.
package contador_cm_uc_pkg;

  // State codes double as the debug display value on db_estado.
  typedef enum logic [3:0] {
    StInicial      = 4'h0,
    StPreparacao   = 4'h1,
    StEsperaPulso  = 4'h2,
    StContagem     = 4'h3,
    StFinalMedida  = 4'h4,
    StErroTimeout  = 4'h6,
    StErroOverflow = 4'h7
  } estado_t;

  localparam logic [3:0] EstInicial      = 4'h0;
  localparam logic [3:0] EstPreparacao   = 4'h1;
  localparam logic [3:0] EstEsperaPulso  = 4'h2;
  localparam logic [3:0] EstContagem     = 4'h3;
  localparam logic [3:0] EstFinalMedida  = 4'h4;
  localparam logic [3:0] EstErroTimeout  = 4'h6;
  localparam logic [3:0] EstErroOverflow = 4'h7;

  // 25 ms at 50 MHz.
  localparam int unsigned TimeoutDefault = 1250000;
  localparam int unsigned NtDefault      = 21;

  function automatic logic estado_erro(input logic [3:0] codigo);
    return (codigo == EstErroTimeout) || (codigo == EstErroOverflow);
  endfunction

endpackage

// File: rtl/contador_cm_uc_if.sv
// Handshake between the control unit and the cm-counting datapath / requester.
interface contador_cm_uc_if;
  logic       medir;
  logic       pulso;
  logic       tick;
  logic       fim;
  logic       zera_tick;
  logic       conta_tick;
  logic       zera_bcd;
  logic       conta_bcd;
  logic       pronto;
  logic       erro;
  logic [3:0] db_estado;

  modport master (
    output medir, pulso, tick, fim,
    input  zera_tick, conta_tick, zera_bcd, conta_bcd, pronto, erro, db_estado
  );

  modport slave (
    input  medir, pulso, tick, fim,
    output zera_tick, conta_tick, zera_bcd, conta_bcd, pronto, erro, db_estado
  );
endinterface

// File: rtl/contador_m.sv
// Modulo-M up counter with synchronous clear; fim flags the terminal count M-1.
module contador_m #(
  parameter int unsigned M = 100,
  parameter int unsigned N = 7
) (
  input  logic clock,
  input  logic zera_s,
  input  logic conta,
  output logic fim
);

  logic [N-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (zera_s) begin
      q_d = '0;
    end else if (conta) begin
      if (q_q == N'(M - 1)) begin
        q_d = '0;
      end else begin
        q_d = q_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    q_q <= q_d;
  end

  assign fim = (q_q == N'(M - 1));

endmodule

// File: rtl/contador_cm_uc.sv
// Control unit for one ultrasonic echo measurement: sync echo, gate ticks into the
// BCD counter while the echo is high, flag timeout or overflow.
module contador_cm_uc
  import contador_cm_uc_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault,
  parameter int unsigned NT      = NtDefault
) (
  input logic             clock,
  input logic             reset,
  contador_cm_uc_if.slave bus
);

  estado_t estado_d, estado_q;

  logic pulso_meta_q, pulso_s_q;
  logic timeout_zera, timeout_conta, timeout_fim;

  logic zera_tick, conta_tick, zera_bcd, conta_bcd, pronto, erro;

  // Two-flop synchronizer on the raw echo; no filtering beyond that.
  always_ff @(posedge clock) begin
    if (reset) begin
      pulso_meta_q <= 1'b0;
      pulso_s_q    <= 1'b0;
    end else begin
      pulso_meta_q <= bus.pulso;
      pulso_s_q    <= pulso_meta_q;
    end
  end

  contador_m #(
    .M(TIMEOUT),
    .N(NT)
  ) u_timeout (
    .clock (clock),
    .zera_s(reset | timeout_zera),
    .conta (timeout_conta),
    .fim   (timeout_fim)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= StInicial;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    estado_d      = estado_q;
    zera_tick     = 1'b0;
    conta_tick    = 1'b0;
    zera_bcd      = 1'b0;
    conta_bcd     = 1'b0;
    pronto        = 1'b0;
    erro          = 1'b0;
    timeout_zera  = 1'b0;
    timeout_conta = 1'b0;

    unique case (estado_q)
      StInicial: begin
        if (bus.medir) estado_d = StPreparacao;
      end

      StPreparacao: begin
        zera_tick    = 1'b1;
        zera_bcd     = 1'b1;
        timeout_zera = 1'b1;
        estado_d     = StEsperaPulso;
      end

      StEsperaPulso: begin
        timeout_conta = 1'b1;
        // An echo arriving on the last allowed cycle still counts as a measurement.
        if (pulso_s_q) begin
          estado_d = StContagem;
        end else if (timeout_fim) begin
          estado_d = StErroTimeout;
        end
      end

      StContagem: begin
        conta_tick = pulso_s_q;
        // Suppress the increment at 999 so the digits hold the saturated value.
        conta_bcd  = pulso_s_q & bus.tick & ~bus.fim;
        if (!pulso_s_q) begin
          estado_d = StFinalMedida;
        end else if (bus.tick && bus.fim) begin
          estado_d = StErroOverflow;
        end
      end

      StFinalMedida: begin
        pronto   = 1'b1;
        estado_d = StInicial;
      end

      StErroTimeout, StErroOverflow: begin
        erro = 1'b1;
        if (bus.medir) estado_d = StPreparacao;
      end

      default: begin
        estado_d = StInicial;
      end
    endcase
  end

  assign bus.zera_tick  = zera_tick;
  assign bus.conta_tick = conta_tick;
  assign bus.zera_bcd   = zera_bcd;
  assign bus.conta_bcd  = conta_bcd;
  assign bus.pronto     = pronto;
  assign bus.erro       = erro;
  assign bus.db_estado  = estado_q;

endmodule

// File: tb/tb_contador_cm_uc.sv
// Self-checking bench for contador_cm_uc with a stub tick datapath and TIMEOUT=100.
module tb_contador_cm_uc;
  import contador_cm_uc_pkg::*;

  localparam int unsigned To = 100;
  localparam int unsigned Nt = 7;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  contador_cm_uc_if bus ();

  contador_cm_uc #(
    .TIMEOUT(To),
    .NT     (Nt)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Stub tick generator: tick high while its count sits at r_tick-1.
  int   r_tick     = 10;
  int   tq         = 0;
  bit   tick_force = 1'b0;
  logic tick_val   = 1'b0;
  logic fim_val    = 1'b0;

  always @(posedge clock) begin
    if (bus.zera_tick) tq <= 0;
    else if (bus.conta_tick) tq <= (tq >= r_tick - 1) ? 0 : tq + 1;
  end

  assign bus.tick = tick_force ? tick_val : (tq == r_tick - 1);
  assign bus.fim  = fim_val;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int   n_bcd, n_ct, n_zera, n_pronto, pronto_cyc, n_erro_rise, erro_cyc, n_zmis;
  logic erro_prev;
  logic [3:0] trace[$];

  typedef struct {
    logic       tick;
    logic       fim;
    logic       exp_bcd;
    logic [3:0] exp_next;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    n_bcd = 0; n_ct = 0; n_zera = 0; n_pronto = 0; n_erro_rise = 0; n_zmis = 0;
    pronto_cyc = -1; erro_cyc = -1; erro_prev = bus.erro;
    trace.delete();
    trace.push_back(bus.db_estado);
  endtask

  // Sample at the falling edge (outputs after edge cyc), then advance one edge.
  task automatic step();
    @(negedge clock);
    if (bus.conta_bcd) n_bcd++;
    if (bus.conta_tick) n_ct++;
    if (bus.zera_tick) n_zera++;
    if (bus.zera_tick != bus.zera_bcd) n_zmis++;
    if (bus.pronto) begin
      n_pronto++;
      pronto_cyc = cyc;
    end
    if (bus.erro && !erro_prev) begin
      n_erro_rise++;
      if (erro_cyc < 0) erro_cyc = cyc;
    end
    erro_prev = bus.erro;
    if (trace[$] != bus.db_estado) trace.push_back(bus.db_estado);
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.medir = 1'b0; bus.pulso = 1'b0;
    tick_force = 1'b0; tick_val = 1'b0; fim_val = 1'b0;
    step(); step();
    reset = 1'b0;
    step(); step();
    clear_mon();
  endtask

  task automatic enter_contagem(input string tag);
    int guard;
    do_reset();
    bus.medir = 1'b1; bus.pulso = 1'b1;
    step();
    bus.medir = 1'b0;
    guard = 0;
    while (bus.db_estado != EstContagem && guard < 20) begin
      step();
      guard++;
    end
    chk({tag, "_enter"}, int'(bus.db_estado), int'(EstContagem));
  endtask

  // Measurement relative to medir at cycle m: echo high after edges k..k+w-1.
  task automatic run_meas(input int d, input int w, input int r, input string tag);
    int s, m, k, hi, lo, t_end, n_exp;
    bit meas;
    r_tick = r;
    clear_mon();
    s = cyc; m = s + 4; k = m + d;
    if (k < s + 1) k = s + 1;
    // Synced echo is visible on cycles k+2..k+w+1; the wait window is m+2..m+101.
    hi = (k + 2 > m + 2) ? k + 2 : m + 2;
    lo = (k + w + 1 < m + 101) ? k + w + 1 : m + 101;
    meas = (hi <= lo);
    t_end = ((k + w > m + 102) ? k + w : m + 102) + 6;
    while (cyc < t_end) begin
      bus.medir = (cyc == m);
      bus.pulso = (cyc >= k) && (cyc < k + w);
      step();
    end
    bus.medir = 1'b0; bus.pulso = 1'b0;
    chk({tag, "_zera"}, n_zera, 1);
    chk({tag, "_zera_pair"}, n_zmis, 0);
    if (meas) begin
      n_exp = k + w + 1 - hi;
      chk({tag, "_conta_tick"}, n_ct, n_exp);
      chk({tag, "_conta_bcd"}, n_bcd, n_exp / r);
      chk({tag, "_pronto_n"}, n_pronto, 1);
      chk({tag, "_pronto_at"}, pronto_cyc - s, k + w + 3 - s);
      chk({tag, "_no_erro"}, n_erro_rise, 0);
    end else begin
      chk({tag, "_erro_at"}, erro_cyc - s, m + 102 - s);
      chk({tag, "_no_pronto"}, n_pronto, 0);
      chk({tag, "_state6"}, int'(bus.db_estado), int'(EstErroTimeout));
      chk({tag, "_bcd0"}, n_bcd, 0);
    end
  endtask

  initial begin
    int guard;
    logic [3:0] exp_trace[6];
    vecs[0] = '{tick: 1'b0, fim: 1'b0, exp_bcd: 1'b0, exp_next: EstContagem};
    vecs[1] = '{tick: 1'b1, fim: 1'b0, exp_bcd: 1'b1, exp_next: EstContagem};
    vecs[2] = '{tick: 1'b0, fim: 1'b1, exp_bcd: 1'b0, exp_next: EstContagem};
    vecs[3] = '{tick: 1'b1, fim: 1'b1, exp_bcd: 1'b0, exp_next: EstErroOverflow};
    exp_trace = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h0};
    bus.medir = 1'b0; bus.pulso = 1'b0;

    // Reset state
    do_reset();
    chk("reset_state", int'(bus.db_estado), 0);
    chk("reset_outs", int'({bus.zera_tick, bus.conta_tick, bus.zera_bcd, bus.conta_bcd,
                            bus.pronto, bus.erro}), 0);

    // Basic measurement: 40 conta_tick cycles -> 4 increments
    run_meas(5, 41, 10, "basic");
    chk("basic_bcd4", n_bcd, 4);
    chk("basic_trace_len", trace.size(), 6);
    for (int i = 0; i < 6 && i < trace.size(); i++) begin
      chk($sformatf("basic_trace%0d", i), int'(trace[i]), int'(exp_trace[i]));
    end

    // Echo never arrives -> timeout, then recover with medir
    run_meas(300, 2, 10, "timeout");
    chk("timeout_erro_lvl", int'(bus.erro), 1);
    bus.medir = 1'b1;
    step();
    bus.medir = 1'b0;
    chk("recover_state", int'(bus.db_estado), int'(EstPreparacao));
    chk("recover_erro", int'(bus.erro), 0);
    chk("recover_zera", int'(bus.zera_tick & bus.zera_bcd), 1);
    step();
    chk("recover_espera", int'(bus.db_estado), int'(EstEsperaPulso));

    // Mealy decode in contagem
    for (int i = 0; i < 4; i++) begin
      tick_force = 1'b1;
      enter_contagem($sformatf("vec%0d", i));
      tick_force = 1'b1;
      step();
      tick_val = vecs[i].tick; fim_val = vecs[i].fim;
      #2;
      chk($sformatf("vec%0d_bcd", i), int'(bus.conta_bcd), int'(vecs[i].exp_bcd));
      chk($sformatf("vec%0d_ctick", i), int'(bus.conta_tick), 1);
      step();
      chk($sformatf("vec%0d_next", i), int'(bus.db_estado), int'(vecs[i].exp_next));
      tick_val = 1'b0;
      if (vecs[i].exp_next == EstErroOverflow) begin
        chk("ovf_erro", int'(bus.erro), 1);
        clear_mon();
        bus.pulso = 1'b0;
        for (int j = 0; j < 10; j++) step();
        chk("ovf_no_pronto", n_pronto, 0);
        chk("ovf_hold7", int'(bus.db_estado), int'(EstErroOverflow));
      end
      bus.pulso = 1'b0; fim_val = 1'b0;
    end

    // Echo fall and tick&fim in the same cycle: the fall wins
    tick_force = 1'b1;
    enter_contagem("sim");
    tick_force = 1'b1;
    fim_val = 1'b1;
    bus.pulso = 1'b0;
    step(); step();
    chk("sim_still3", int'(bus.db_estado), int'(EstContagem));
    tick_val = 1'b1;
    #2;
    chk("sim_bcd0", int'(bus.conta_bcd), 0);
    step();
    chk("sim_final", int'(bus.db_estado), int'(EstFinalMedida));
    chk("sim_pronto", int'(bus.pronto), 1);
    chk("sim_erro", int'(bus.erro), 0);
    tick_val = 1'b0; fim_val = 1'b0; tick_force = 1'b0;

    // Reset during contagem with echo high
    enter_contagem("rst");
    step(); step();
    chk("rst_ctick_before", int'(bus.conta_tick), 1);
    reset = 1'b1;
    step();
    chk("rst_state", int'(bus.db_estado), 0);
    chk("rst_outs", int'({bus.zera_tick, bus.conta_tick, bus.zera_bcd, bus.conta_bcd,
                          bus.pronto, bus.erro}), 0);
    reset = 1'b0; bus.pulso = 1'b0;
    step(); step(); step();
    run_meas(3, 25, 4, "after_rst");

    // medir held high: no restart mid-measurement, back-to-back runs
    do_reset();
    r_tick = 10;
    bus.medir = 1'b1;
    for (int run = 0; run < 2; run++) begin
      clear_mon();
      guard = 0;
      while (bus.db_estado != EstEsperaPulso && guard < 10) begin
        step();
        guard++;
      end
      chk($sformatf("held%0d_espera", run), int'(bus.db_estado), int'(EstEsperaPulso));
      step(); step(); step();
      bus.pulso = 1'b1;
      for (int j = 0; j < 20; j++) step();
      bus.pulso = 1'b0;
      guard = 0;
      while (n_pronto == 0 && guard < 20) begin
        step();
        guard++;
      end
      chk($sformatf("held%0d_zera", run), n_zera, 1);
      chk($sformatf("held%0d_bcd", run), n_bcd, 1);
      chk($sformatf("held%0d_inicial", run), int'(bus.db_estado), int'(EstInicial));
      step();
      chk($sformatf("held%0d_restart", run), int'(bus.db_estado), int'(EstPreparacao));
      chk($sformatf("held%0d_pronto1", run), n_pronto, 1);
    end
    bus.medir = 1'b0;

    // Randomized measurements against the window model
    do_reset();
    for (int i = 0; i < 30; i++) begin
      int d, w, r;
      d = int'($urandom_range(113)) - 3;
      w = 2 + int'($urandom_range(48));
      r = 2 + int'($urandom_range(10));
      run_meas(d, w, r, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
